// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver with a small scan-code FIFO.
//
// This block synchronizes the pad-side PS/2 clock and data. It decodes
// 11-bit frames (start, 8 data bits LSB first, parity, stop). Each good
// byte is pushed into a FIFO_DEPTH-entry FIFO that the core drains with
// rx_pop.
//
// Parameters:
//   TIMEOUT_CYCLES - idle clk cycles allowed between PS/2 falling edges mid-frame
//   FIFO_DEPTH     - scan-code FIFO entries (power of two, >= 2)
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset
//   ps2_clk   - asynchronous PS/2 clock from the pad
//   ps2_data  - asynchronous PS/2 data from the pad
//   rx_pop    - consume the FIFO head this cycle (ignored when empty)
//   rx_data   - FIFO head scan code, 0x00 while empty
//   rx_valid  - FIFO non-empty
//   frame_err - one-cycle pulse on a rejected frame (bad stop, timeout, parity)
//   overflow  - one-cycle pulse when a good byte is dropped on a full FIFO
//
// Build option:
//   PS2_PARITY_CHECK_EN - when defined, frames failing odd parity are rejected.
//                         When undefined, the parity bit is ignored.

`timescale 1ns/1ps

module ps2_keyboard_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_pop,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and falling-edge detect
    // ------------------------------------------------------------------
    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q;

    // ------------------------------------------------------------------
    // Frame decoder FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [TW-1:0]   timeout_q, timeout_d;
    logic            push_q, push_d;
    logic            err_q, err_d;
    logic            parity_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic            parity_q, parity_d;

    // Odd parity over data and parity bit.
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        timeout_d = timeout_q;
        push_d    = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = 3'd0;
                timeout_d = '0;
                if (fall && !data_sync_q) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = data_sync_q;
`endif
                    state_d = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (data_sync_q && parity_ok) begin
                        push_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Mid-frame watchdog: any falling edge restarts the count.
        if (state_q != StIdle) begin
            if (fall) begin
                timeout_d = '0;
            end else if (timeout_q == TimeoutLast) begin
                timeout_d = '0;
                state_d   = StIdle;
                err_d     = 1'b1;
            end else begin
                timeout_d = timeout_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            timeout_q <= '0;
            push_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            timeout_q <= timeout_d;
            push_q    <= push_d;
            err_q     <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign frame_err = err_q;

    // ------------------------------------------------------------------
    // Scan-code FIFO; the pointer MSB distinguishes full from empty.
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          empty, full, pop_en, push_en;
    logic          overflow_q;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_en  = rx_pop & ~empty;
    // A pop in the same cycle frees the slot being written.
    assign push_en = push_q & (~full | pop_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            overflow_q <= push_q & full & ~pop_en;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign rx_valid = ~empty;
    assign rx_data  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed self-checking bench for ps2_keyboard_rx.
// Drives PS/2 frames with a 100-clk half-period against TIMEOUT_CYCLES=400.

`timescale 1ns/1ps

module tb_ps2_keyboard_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rx_pop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int ovf_cnt = 0;
    int fall_cyc = 0;

    ps2_keyboard_rx #(
        .TIMEOUT_CYCLES(400),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_pop   (rx_pop),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (overflow) begin
            ovf_cnt <= ovf_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic bad_par, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == 9) return (~^d) ^ bad_par;
        return 1'b1;
    endfunction

    // Sends frame bits first..last, each as a full high/low clock period.
    task automatic send_bits(input logic [7:0] d, input logic bad_par, input int first,
                             input int last);
        for (int i = first; i <= last; i++) begin
            ps2_data = frame_bit(d, bad_par, i);
            tick(100);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            tick(100);
            ps2_clk  = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        send_bits(d, bad_par, 0, 10);
        tick(20);
    endtask

    task automatic pop();
        rx_pop = 1'b1;
        tick(1);
        rx_pop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int o0;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rx_pop   = 1'b0;
        tick(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_err", frame_err, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick(5);

        // Good frame 0x1C; push one cycle after the stop edge, valid the cycle after.
        send_bits(8'h1C, 1'b0, 0, 9);
        ps2_data = 1'b1;
        tick(100);
        ps2_clk = 1'b0;
        tick(3);
        check("t1_valid_early", rx_valid, 0);
        tick(1);
        check("t1_valid", rx_valid, 1);
        check("t1_data", rx_data, 8'h1C);
        tick(96);
        ps2_clk = 1'b1;
        tick(20);
        pop();
        check("t1_pop_valid", rx_valid, 0);

        // Bad parity.
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("t2_err", err_cnt - e0, 1);
        check("t2_valid", rx_valid, 0);
`else
        check("t2_err", err_cnt - e0, 0);
        check("t2_valid", rx_valid, 1);
        check("t2_data", rx_data, 8'h1C);
        pop();
`endif

        // Stop bit 0 is rejected.
        e0 = err_cnt;
        send_bits(8'h3A, 1'b0, 0, 9);
        ps2_data = 1'b0;
        tick(100);
        ps2_clk = 1'b0;
        tick(100);
        ps2_clk = 1'b1;
        tick(20);
        check("t2b_err", err_cnt - e0, 1);
        check("t2b_valid", rx_valid, 0);

        // Overflow on the fifth byte; first four survive.
        e0 = err_cnt;
        o0 = ovf_cnt;
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k), 1'b0);
        end
        check("t3_ovf_none", ovf_cnt - o0, 0);
        send_frame(8'h05, 1'b0);
        check("t3_ovf", ovf_cnt - o0, 1);
        for (int k = 1; k <= 4; k++) begin
            check("t3_pop_data", rx_data, k);
            pop();
        end
        check("t3_empty", rx_valid, 0);
        check("t3_err", err_cnt - e0, 0);

        // Timeout after start + 4 data bits.
        e0 = err_cnt;
        send_bits(8'hA5, 1'b0, 0, 4);
        for (int i = 0; i < 600 && err_cnt == e0; i++) begin
            tick(1);
        end
        check("t4_err", err_cnt - e0, 1);
        check("t4_latency", ((err_cyc - fall_cyc) >= 401) && ((err_cyc - fall_cyc) <= 406), 1);
        check("t4_valid", rx_valid, 0);
        send_frame(8'hF0, 1'b0);
        check("t4_next_valid", rx_valid, 1);
        check("t4_next_data", rx_data, 8'hF0);
        check("t4_next_err", err_cnt - e0, 1);
        pop();

        // Reset after the 6th edge of 0x5A.
        e0 = err_cnt;
        send_bits(8'h5A, 1'b0, 0, 4);
        ps2_data = frame_bit(8'h5A, 1'b0, 5);
        tick(100);
        ps2_clk = 1'b0;
        tick(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_rst_valid", rx_valid, 0);
        check("t5_rst_err", frame_err, 0);
        tick(89);
        ps2_clk = 1'b1;
        tick(600);
        check("t5_no_err", err_cnt - e0, 0);
        check("t5_no_push", rx_valid, 0);
        send_frame(8'h5A, 1'b0);
        check("t5_valid", rx_valid, 1);
        check("t5_data", rx_data, 8'h5A);
        pop();

        // Full FIFO, pop coincident with the push of 0x77.
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b0);
        send_frame(8'h44, 1'b0);
        o0 = ovf_cnt;
        send_bits(8'h77, 1'b0, 0, 9);
        ps2_data = 1'b1;
        tick(100);
        ps2_clk = 1'b0;
        tick(3);
        check("t6_head", rx_data, 8'h11);
        rx_pop = 1'b1;
        tick(1);
        rx_pop = 1'b0;
        tick(96);
        ps2_clk = 1'b1;
        tick(20);
        check("t6_ovf", ovf_cnt - o0, 0);
        check("t6_d0", rx_data, 8'h22);
        pop();
        check("t6_d1", rx_data, 8'h33);
        pop();
        check("t6_d2", rx_data, 8'h44);
        pop();
        check("t6_d3", rx_data, 8'h77);
        pop();
        check("t6_empty", rx_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, the idle-clock cycles allowed between PS/2 falling edges mid-frame (1 ms at 50 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of scan-code entries; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1, the asynchronous PS/2 clock from the pad.
REQ-006 SHALL have port ps2_data, input, 1, the asynchronous PS/2 data from the pad.
REQ-007 SHALL have port rx_pop, input, 1, a Core-side request to consume the FIFO head this cycle.
REQ-008 SHALL have port rx_data, output, 8, the FIFO head scan code, valid only while rx_valid=1.
REQ-009 SHALL have port rx_valid, output, 1, asserted while the FIFO is non-empty.
REQ-010 SHALL have port frame_err, output, 1, a one-cycle pulse when a frame is rejected.
REQ-011 SHALL have port overflow, output, 1, a one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a two-flop synchronizer; a falling edge is the synchronized clock being 0 while its previous sample was 1.
REQ-013 SHALL sample the synchronized data only on a detected falling edge.
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-015 SHALL move IDLE->DATA on a falling edge with data=0; a falling edge with data=1 in IDLE SHALL be ignored.
REQ-016 SHALL shift eight DATA bits LSB first using a 3-bit bit counter, then go DATA->PARITY after the 8th bit.
REQ-017 SHALL capture the parity bit in PARITY, then go to STOP.
REQ-018 SHALL accept the frame in STOP when the stop bit is 1 (and parity passes, see REQ-027), push the byte, and return to IDLE.
REQ-019 SHALL, on a stop bit of 0, pulse frame_err, not push, and return to IDLE.
REQ-020 SHALL count clk cycles since the last falling edge in any non-IDLE state; on reaching TIMEOUT_CYCLES it SHALL discard the partial frame, pulse frame_err, and return to IDLE.
REQ-021 SHALL push the accepted byte in the cycle after the STOP-sampling edge; rx_valid SHALL rise on the following cycle when the FIFO was empty.
REQ-022 SHALL, on rx_pop with rx_valid=1, advance the head at the clock edge; rx_pop with rx_valid=0 SHALL be ignored.
REQ-023 SHALL, on simultaneous push and pop when full, perform both, keeping the FIFO full with no overflow pulse.
REQ-024 SHALL, on a push when full without a pop, drop the new byte, keep the contents, and pulse overflow.
REQ-025 SHALL use pointer width log2(FIFO_DEPTH)+1 so the pointers wrap naturally at their full width.

Reset
REQ-026 SHALL, while reset=1 at a clk edge, set FSM=IDLE, the bit and timeout counters=0, the FIFO empty, the synchronizers=1, and rx_valid=0, rx_data=0x00, frame_err=0, overflow=0; a reset mid-frame SHALL discard the partial byte, and the next complete frame after release SHALL be received normally.

Configuration
REQ-027 SHALL, with macro PS2_PARITY_CHECK_EN defined, require odd parity (data bits plus parity bit have an odd count of ones); a mismatch SHALL pulse frame_err in STOP with no push.
REQ-028 SHALL, without PS2_PARITY_CHECK_EN, ignore the parity bit and never raise frame_err for parity.

Verification (TIMEOUT_CYCLES=400; PS/2 half-period 100 clk)
REQ-029 SHALL cover: frame 0x1C, parity 0, stop 1 -> rx_valid=1 with rx_data=0x1C; rx_pop -> rx_valid=0 the next cycle.
REQ-030 SHALL cover: frame 0x1C with parity 1, macro defined -> frame_err pulses once and rx_valid stays 0; macro undefined -> 0x1C is pushed.
REQ-031 SHALL cover: frames 0x01..0x05 with no pop -> overflow pulses on 0x05, then pops return 0x01,0x02,0x03,0x04.
REQ-032 SHALL cover: start bit plus 4 data bits, then ps2_clk held high -> frame_err 400 cycles after the last edge; a following frame 0xF0 is received as 0xF0.
REQ-033 SHALL cover: reset asserted for 1 cycle after the 6th edge of frame 0x5A -> no push; a following frame 0x5A is received as 0x5A.
REQ-034 SHALL cover: FIFO full with rx_pop coincident with the push of 0x77 -> no overflow pulse, 0x77 ends up last, and depth stays 4.
